// File: rtl/phase_acc.sv
// phase_acc -- block accumulator for phase_det measurements.
//
// Sums blocks of 2^LOG2_N consecutive i_count samples into one
// TIC_BITS+LOG2_N wide result. The result is presented on a valid/ready
// handshake. The first SKIP_FIRST samples after each enable are discarded.
// A block that completes while the previous result is still unread is
// dropped, and the sticky o_ovf flag is set.
//
// Optional feature macro: PHASE_ACC_MINMAX_EN. When it is defined, the
// module also reports the minimum and maximum sample of the delivered block.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_en         enable; low returns to idle and discards any partial block
//   i_count      measurement from phase_det
//   i_count_rdy  one-cycle strobe, i_count valid
//   o_sum        block sum, held stable while o_valid and not accepted
//   o_valid      result available
//   i_ready      consumer accepts the result when o_valid & i_ready
//   o_ovf        sticky: at least one completed block was dropped
//   i_ovf_clr    clears o_ovf (a same-cycle set wins)
//   o_blk_cnt    blocks delivered to the output register, wraps
//   o_min/o_max  (PHASE_ACC_MINMAX_EN only) min/max sample of the block
//
// State table:
//   IDLE | disabled; accumulator, sample and skip counters reloaded
//   SKIP | discarding the first SKIP_FIRST samples after enable
//   ACC  | accumulating samples into the current block
module phase_acc #(
    parameter int TIC_BITS   = 9,
    parameter int LOG2_N     = 4,
    parameter int SKIP_FIRST = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [TIC_BITS-1:0]        i_count,
    input  logic                       i_count_rdy,
    output logic [TIC_BITS+LOG2_N-1:0] o_sum,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_ovf,
    input  logic                       i_ovf_clr,
    output logic [15:0]                o_blk_cnt
`ifdef PHASE_ACC_MINMAX_EN
    ,
    output logic [TIC_BITS-1:0]        o_min,
    output logic [TIC_BITS-1:0]        o_max
`endif
);

    localparam int SUM_W = TIC_BITS + LOG2_N;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;

    localparam logic [1:0]        SKIP_INIT = 2'(SKIP_FIRST);
    localparam logic [LOG2_N-1:0] CNT_LAST  = '1;

    logic [1:0]        state;
    logic [SUM_W-1:0]  acc;
    logic [LOG2_N-1:0] smp_cnt;
    logic [1:0]        skip_cnt;

    logic             take;
    logic             blk_last;
    logic             load_ok;
    logic [SUM_W-1:0] sum;

    // A strobe only counts while enabled in ACC. A falling i_en overrides it.
    assign take     = (state == ST_ACC) && i_en && i_count_rdy;
    assign blk_last = take && (smp_cnt == CNT_LAST);
    assign sum      = acc + SUM_W'(i_count);
    // The output register is free if it is empty or is being read this cycle.
    assign load_ok  = !o_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            smp_cnt  <= '0;
            skip_cnt <= SKIP_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc      <= '0;
                    smp_cnt  <= '0;
                    skip_cnt <= SKIP_INIT;
                    if (i_en) begin
                        state <= (SKIP_FIRST > 0) ? ST_SKIP : ST_ACC;
                    end
                end
                ST_SKIP: begin
                    if (!i_en) begin
                        state <= ST_IDLE;
                    end else if (i_count_rdy) begin
                        skip_cnt <= skip_cnt - 2'd1;
                        if (skip_cnt == 2'd1) begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (!i_en) begin
                        state <= ST_IDLE;
                    end else if (blk_last) begin
                        // The next block starts on the very next strobe.
                        acc     <= '0;
                        smp_cnt <= '0;
                    end else if (take) begin
                        acc     <= sum;
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sum     <= '0;
            o_valid   <= 1'b0;
            o_ovf     <= 1'b0;
            o_blk_cnt <= '0;
        end else begin
            if (blk_last && load_ok) begin
                o_sum     <= sum;
                o_valid   <= 1'b1;
                o_blk_cnt <= o_blk_cnt + 16'd1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            // A dropped block wins over a clear in the same cycle.
            o_ovf <= (blk_last && !load_ok) || (o_ovf && !i_ovf_clr);
        end
    end

`ifdef PHASE_ACC_MINMAX_EN
    logic [TIC_BITS-1:0] run_min;
    logic [TIC_BITS-1:0] run_max;
    logic [TIC_BITS-1:0] nxt_min;
    logic [TIC_BITS-1:0] nxt_max;

    assign nxt_min = (i_count < run_min) ? i_count : run_min;
    assign nxt_max = (i_count > run_max) ? i_count : run_max;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_min <= '1;
            run_max <= '0;
            o_min   <= '0;
            o_max   <= '0;
        end else begin
            if (state != ST_ACC || blk_last) begin
                run_min <= '1;
                run_max <= '0;
            end else if (take) begin
                run_min <= nxt_min;
                run_max <= nxt_max;
            end
            if (blk_last && load_ok) begin
                o_min <= nxt_min;
                o_max <= nxt_max;
            end
        end
    end
`endif

endmodule

// File: doc/phase_acc.md
Name: phase_acc

Overview:
- Downstream consumer of phase_det: takes each o_count/o_count_rdy measurement and sums blocks of 2^LOG2_N samples into one wider result.
- Results go to the register/host readout path over a valid/ready handshake. This decimates the measurement rate and adds LOG2_N bits of resolution.
- Blocks completed while the previous result is still unread are dropped and flagged.

Parameters:
- TIC_BITS, 9, width of incoming measurement (matches phase_det TIC_BITS)
- LOG2_N, 4, log2 of samples per block (1..16)
- SKIP_FIRST, 1, number of samples discarded after each i_en rising edge (0..3); covers phase_det's unaligned first measurement

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  enable; low = idle, partial block discarded
- i_count  in  TIC_BITS  measurement from phase_det
- i_count_rdy  in  1  one-cycle strobe, i_count valid
- o_sum  out  TIC_BITS+LOG2_N  block sum, stable while o_valid
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result when o_valid&i_ready
- o_ovf  out  1  sticky: at least one completed block dropped
- i_ovf_clr  in  1  clears o_ovf
- o_blk_cnt  out  16  count of blocks delivered to output register, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0 (o_sum=0, o_valid=0, o_ovf=0, o_blk_cnt=0); accumulator=0, sample counter=0, skip counter=SKIP_FIRST, state=IDLE.
- States and transitions:
  - IDLE: taken while i_en=0. Accumulator, sample counter and skip counter are reloaded every cycle.
  - IDLE -> SKIP on i_en=1 if SKIP_FIRST>0, else IDLE -> ACC.
  - SKIP: each i_count_rdy decrements the skip counter and the sample is ignored. Counter reaching 0 -> ACC.
  - ACC: each i_count_rdy adds i_count, zero-extended, to the accumulator and increments the sample counter.
  - On the 2^LOG2_N-th sample, sum = acc + i_count is computed combinationally, then the accumulator and sample counter restart at 0 in the same cycle. No sample is lost between blocks.
- i_en falling in any state: next state IDLE, partial block discarded. o_valid/o_sum are untouched; a pending result remains readable.
- Output register load (cycle after the final sample's strobe, i.e. 1-cycle latency):
  - If o_valid=0, or o_valid&i_ready in that same cycle: o_sum<=sum, o_valid<=1, o_blk_cnt increments.
  - Else: block dropped, o_ovf<=1, o_sum unchanged.
- Handshake:
  - o_valid&i_ready with no new load -> o_valid<=0 next cycle.
  - o_sum must not change while o_valid=1 and not accepted.
- Widths: accumulator TIC_BITS+LOG2_N bits, cannot overflow. Max sum = (2^TIC_BITS-1)*2^LOG2_N.
- o_ovf:
  - i_ovf_clr clears it.
  - Same-cycle set and clear -> set wins (o_ovf=1).
- i_count_rdy while i_rst=1: ignored.

Optional Feature:
- Macro: PHASE_ACC_MINMAX_EN
- Defined:
  - Adds ports o_min and o_max (out, TIC_BITS each).
  - Each tracks the min/max of samples accumulated in the block just delivered, latched with o_sum under the same load/hold rules.
  - Running min initialised to all-ones and running max to 0 at each block start and in IDLE.
  - Reset value 0 for both outputs.
- Not defined: ports absent, no min/max logic.

Test Plan:
- TIC_BITS=9, LOG2_N=2, SKIP_FIRST=1:
  - Reset, en=1, strobes 7,10,20,30,40, i_ready=1 -> 7 skipped; o_sum=100, o_valid pulses one cycle after strobe of 40; o_blk_cnt=1.
  - All samples 511, 4 per block, i_ready=1 -> o_sum=2044 (max value, no wrap).
  - i_ready=0, feed 2 full blocks (sums 40 then 80) -> o_sum stays 40, o_ovf=1. Assert i_ready -> o_valid drops. Pulse i_ovf_clr -> o_ovf=0.
  - i_en low after 2 of 4 samples (5,5), re-enable, skip one, feed 1,2,3,4 -> o_sum=10; partial discarded.
  - Back-to-back: block completes in the same cycle o_valid&i_ready -> new sum loaded, o_valid stays 1, no o_ovf.
  - PHASE_ACC_MINMAX_EN defined, samples 9,3,300,12 -> o_min=3, o_max=300, o_sum=324.
